// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: FSM states, lane geometry,
// and the byte-lane extraction helper.
package mem_pkg;

  localparam int unsigned WORD_W    = 48;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned LANES     = WORD_W / LANE_W;
  localparam logic [2:0]  LAST_LANE = 3'(LANES - 1);
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned TAG_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                 input logic [2:0]        idx);
    return word[int'(idx)*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Execute-stage handshake plus byte-wide RAM port of the memory stage.
// slave = memory_access_unit side, master = environment side.
interface memory_access_unit_if #(
  parameter int unsigned DATA_WIDTH = mem_pkg::WORD_W,
  parameter int unsigned BYTE_WIDTH = mem_pkg::LANE_W,
  parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_W,
  parameter int unsigned TAG_WIDTH  = mem_pkg::TAG_W
);

  logic                  valid_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic [DATA_WIDTH-1:0] exec_out;
  logic [DATA_WIDTH-1:0] write_data;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  stall;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic                  result_is_load;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic                  protocol_error;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BYTE_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [BYTE_WIDTH-1:0] mem_rdata;

  modport slave (
    input  valid_in, mem_read_in, mem_write_in, exec_out, write_data, tag_in, mem_rdata,
    output stall, result, result_valid, result_is_load, tag_out, protocol_error,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output valid_in, mem_read_in, mem_write_in, exec_out, write_data, tag_in, mem_rdata,
    input  stall, result, result_valid, result_is_load, tag_out, protocol_error,
           mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/lane_counter.sv
// Byte-lane index for serialised accesses: clear, increment, last-lane flag.
module lane_counter #(
  parameter logic [2:0] LAST = mem_pkg::LAST_LANE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic [2:0] o_k,
  output logic       o_is_last
);

  logic [2:0] r_k;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_k <= '0;
    end else if (i_inc) begin
      r_k <= r_k + 3'd1;
    end
  end

  assign o_k       = r_k;
  assign o_is_last = (r_k == LAST);

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: serialises 48-bit loads/stores into byte accesses on a
// synchronous byte RAM, stalls upstream while busy, passes ALU results through.
module memory_access_unit #(
  parameter int unsigned DATA_WIDTH = mem_pkg::WORD_W,
  parameter int unsigned BYTE_WIDTH = mem_pkg::LANE_W,
  parameter int unsigned LANES      = mem_pkg::LANES,
  parameter int unsigned ADDR_WIDTH = mem_pkg::ADDR_W,
  parameter int unsigned TAG_WIDTH  = mem_pkg::TAG_W
) (
  input logic                 clk,
  input logic                 rst,
  memory_access_unit_if.slave bus
);

  import mem_pkg::*;

  state_t                           r_state;
  logic [ADDR_WIDTH-1:0]            r_base;
  logic [DATA_WIDTH-1:0]            r_wdata;
  logic [DATA_WIDTH-1:0]            r_exec;
  logic [TAG_WIDTH-1:0]             r_tag;
  logic [DATA_WIDTH-BYTE_WIDTH-1:0] r_load;
  logic [DATA_WIDTH-1:0]            r_result;
  logic                             r_result_valid;
  logic                             r_result_is_load;
  logic [TAG_WIDTH-1:0]             r_tag_out;
  logic                             r_protocol_error;
  logic [ADDR_WIDTH-1:0]            r_mem_addr;
  logic [BYTE_WIDTH-1:0]            r_mem_wdata;
  logic                             r_mem_we;
  logic                             r_mem_re;

  logic [2:0] w_k;
  logic       w_is_last;
  logic       w_clear;
  logic       w_inc;
  logic [2:0] w_k_next;

  assign w_clear  = (r_state == IDLE) || (r_state == DRAIN);
  assign w_inc    = ((r_state == WRITE) || (r_state == READ)) && !w_is_last;
  assign w_k_next = w_k + 3'd1;

  lane_counter #(
    .LAST (3'(LANES - 1))
  ) u_lane_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_inc     (w_inc),
    .o_k       (w_k),
    .o_is_last (w_is_last)
  );

  // RAM drive is registered one lane ahead so each WRITE/READ cycle presents lane k.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_base           <= '0;
      r_wdata          <= '0;
      r_exec           <= '0;
      r_tag            <= '0;
      r_load           <= '0;
      r_result         <= '0;
      r_result_valid   <= 1'b0;
      r_result_is_load <= 1'b0;
      r_tag_out        <= '0;
      r_protocol_error <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_mem_we         <= 1'b0;
      r_mem_re         <= 1'b0;
    end else begin
      r_result_valid   <= 1'b0;
      r_protocol_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          if (bus.valid_in) begin
            r_base           <= bus.exec_out[ADDR_WIDTH-1:0];
            r_wdata          <= bus.write_data;
            r_exec           <= bus.exec_out;
            r_tag            <= bus.tag_in;
            r_protocol_error <= bus.mem_read_in && bus.mem_write_in;
            if (bus.mem_write_in) begin
              r_state     <= WRITE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= bus.exec_out[ADDR_WIDTH-1:0];
              r_mem_wdata <= lane_sel(bus.write_data, 3'd0);
            end else if (bus.mem_read_in) begin
              r_state    <= READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= bus.exec_out[ADDR_WIDTH-1:0];
            end else begin
              r_result         <= bus.exec_out;
              r_result_valid   <= 1'b1;
              r_result_is_load <= 1'b0;
              r_tag_out        <= bus.tag_in;
            end
          end
        end
        WRITE: begin
          if (w_is_last) begin
            r_state          <= IDLE;
            r_mem_we         <= 1'b0;
            r_result         <= r_exec;
            r_result_valid   <= 1'b1;
            r_result_is_load <= 1'b0;
            r_tag_out        <= r_tag;
          end else begin
            r_mem_addr  <= r_base + ADDR_WIDTH'(w_k_next);
            r_mem_wdata <= lane_sel(r_wdata, w_k_next);
          end
        end
        READ: begin
          // Read data lags mem_re by one cycle, so lane k-1 lands here.
          if (w_k != 3'd0) begin
            r_load[int'(w_k - 3'd1)*BYTE_WIDTH +: BYTE_WIDTH] <= bus.mem_rdata;
          end
          if (w_is_last) begin
            r_state  <= DRAIN;
            r_mem_re <= 1'b0;
          end else begin
            r_mem_addr <= r_base + ADDR_WIDTH'(w_k_next);
          end
        end
        DRAIN: begin
          r_state          <= IDLE;
          r_result         <= {bus.mem_rdata, r_load};
          r_result_valid   <= 1'b1;
          r_result_is_load <= 1'b1;
          r_tag_out        <= r_tag;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall          = (r_state != IDLE);
  assign bus.result         = r_result;
  assign bus.result_valid   = r_result_valid;
  assign bus.result_is_load = r_result_is_load;
  assign bus.tag_out        = r_tag_out;
  assign bus.protocol_error = r_protocol_error;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_re         = r_mem_re;

endmodule
